// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_pkg
// Description : Shared constants, state encoding and bit-reverse helper for
//               the 64-point FFT datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int N_POINTS = 64;
    localparam int LOG2N    = 6;
    localparam int DW       = 16;
    localparam int SAMPLE_W = 32;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        FULL = 2'd1,
        BUSY = 2'd2
    } state_t;

    function automatic logic [LOG2N-1:0] bitrev6(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_ram_64x32.sv
`default_nettype none
// ============================================================================
// Module      : frame_ram_64x32
// Description : 64-entry frame buffer, one write port and one registered
//               read port with read-before-write behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_ram_64x32
    import fft_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [LOG2N-1:0] i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [LOG2N-1:0] i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [N_POINTS];
    logic [WIDTH-1:0] r_rd_data;

    // Storage array has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/fft_input_loader.sv
`default_nettype none
// ============================================================================
// Module      : fft_input_loader
// Description : Loads 64 optionally pre-scaled complex samples into the frame
//               buffer in bit-reversed order and hands the frame to the core.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_input_loader
    import fft_pkg::*;
#(
    parameter int N        = 64,
    parameter int DW       = 16,
    parameter int IN_SHIFT = 1
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [2*DW-1:0] In_Data,
    input  logic            In_Valid,
    output logic            In_Ready,
    input  logic            Scale,
    input  logic            Flush,
    output logic            Frame_Ready,
    input  logic            Start,
    input  logic            Done,
    input  logic [5:0]      Rd_Addr,
    output logic [2*DW-1:0] Rd_Data,
    output logic [6:0]      Sample_Count
);

    localparam logic [LOG2N:0] c_last = (LOG2N+1)'(N - 1);
    localparam logic [LOG2N:0] c_one  = (LOG2N+1)'(1);

    state_t               r_state;
    logic [LOG2N:0]       r_cnt;
    logic                 w_wr_en;
    logic [LOG2N-1:0]     w_wr_addr;
    logic signed [DW-1:0] w_re;
    logic signed [DW-1:0] w_im;
    logic [2*DW-1:0]      w_wr_data;

    // A beat offered alongside Flush is consumed by the handshake but dropped.
    assign w_wr_en   = In_Valid && (r_state == LOAD) && !Flush;
    assign w_wr_addr = bitrev6(r_cnt[LOG2N-1:0]);

    assign w_re = Scale ? ($signed(In_Data[2*DW-1:DW]) >>> IN_SHIFT)
                        :  $signed(In_Data[2*DW-1:DW]);
    assign w_im = Scale ? ($signed(In_Data[DW-1:0]) >>> IN_SHIFT)
                        :  $signed(In_Data[DW-1:0]);
    assign w_wr_data = {w_re, w_im};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= LOAD;
            r_cnt   <= '0;
        end else if (Flush) begin
            r_state <= LOAD;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (In_Valid) begin
                        r_cnt <= r_cnt + c_one;
                        if (r_cnt == c_last) begin
                            r_state <= FULL;
                        end
                    end
                end
                FULL: begin
                    if (Start) begin
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (Done) begin
                        r_state <= LOAD;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= LOAD;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Counter parks at 64 through FULL and BUSY, so it doubles as the count.
    assign In_Ready     = (r_state == LOAD);
    assign Frame_Ready  = (r_state == FULL);
    assign Sample_Count = r_cnt;

    frame_ram_64x32 #(
        .WIDTH (2*DW)
    ) u_frame_ram (
        .clk       (CLK),
        .rst_n     (nRST),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_wr_data),
        .i_rd_addr (Rd_Addr),
        .o_rd_data (Rd_Data)
    );

endmodule
`default_nettype wire

// File: tb/tb_fft_input_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_input_loader
// Description : Scoreboard bench for fft_input_loader with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_input_loader;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] In_Data;
    logic        In_Valid;
    logic        In_Ready;
    logic        Scale;
    logic        Flush;
    logic        Frame_Ready;
    logic        Start;
    logic        Done;
    logic [5:0]  Rd_Addr;
    logic [31:0] Rd_Data;
    logic [6:0]  Sample_Count;

    fft_input_loader #(
        .N        (64),
        .DW       (16),
        .IN_SHIFT (1)
    ) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .In_Data      (In_Data),
        .In_Valid     (In_Valid),
        .In_Ready     (In_Ready),
        .Scale        (Scale),
        .Flush        (Flush),
        .Frame_Ready  (Frame_Ready),
        .Start        (Start),
        .Done         (Done),
        .Rd_Addr      (Rd_Addr),
        .Rd_Data      (Rd_Data),
        .Sample_Count (Sample_Count)
    );

    always #5 CLK = ~CLK;

    // sel: 0 Rd_Data, 1 Sample_Count, 2 In_Ready, 3 Frame_Ready
    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] act(input int sel);
        case (sel)
            0:       return Rd_Data;
            1:       return {25'd0, Sample_Count};
            2:       return {31'd0, In_Ready};
            default: return {31'd0, Frame_Ready};
        endcase
    endfunction

    function automatic void compare(input string name, input logic [31:0] a,
                                    input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endfunction

    // Monitor: retire every expectation that has come due this cycle.
    always @(negedge CLK) begin : mon
        exp_t e;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            compare(e.name, act(e.sel), e.val);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_now(input string name, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = v;
        e.due  = cyc;
        q.push_back(e);
    endtask

    task automatic check_state(input string p, input logic ir, input logic fr,
                               input logic [6:0] sc);
        expect_now({p, ".in_ready"}, 2, {31'd0, ir});
        expect_now({p, ".frame_ready"}, 3, {31'd0, fr});
        expect_now({p, ".count"}, 1, {25'd0, sc});
    endtask

    task automatic beat(input logic [31:0] d, input logic s);
        In_Valid = 1'b1;
        In_Data  = d;
        Scale    = s;
        step();
        In_Valid = 1'b0;
        Scale    = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, input logic [31:0] v, input string name);
        Rd_Addr = a;
        step();
        expect_now(name, 0, v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 1'b0; In_Data = '0; In_Valid = 1'b0; Scale = 1'b0; Flush = 1'b0;
        Start = 1'b0; Done = 1'b0; Rd_Addr = '0;
        step();
        step();
        check_state("reset", 1'b1, 1'b0, 7'd0);
        expect_now("reset.rd_data", 0, 32'h0);
        nRST = 1'b1;

        // Frame 1: sample k = {k, 0}, unscaled
        for (int k = 0; k < 64; k++) begin
            beat({16'(k), 16'h0000}, 1'b0);
            if (k == 62) check_state("f1_beat62", 1'b1, 1'b0, 7'd63);
        end
        check_state("f1_full", 1'b0, 1'b1, 7'd64);
        rd(6'd32, 32'h0001_0000, "f1_addr32");
        rd(6'd1,  32'h0020_0000, "f1_addr1");
        rd(6'd63, 32'h003F_0000, "f1_addr63");
        rd(6'd0,  32'h0000_0000, "f1_addr0");

        // Input stalls in FULL
        In_Valid = 1'b1;
        In_Data  = 32'hDEAD_BEEF;
        step();
        step();
        check_state("hold", 1'b0, 1'b1, 7'd64);
        In_Valid = 1'b0;
        rd(6'd0, 32'h0000_0000, "hold_no_write");

        Start = 1'b1; step(); Start = 1'b0;
        check_state("busy", 1'b0, 1'b0, 7'd64);
        Done = 1'b1; Start = 1'b1; step(); Done = 1'b0; Start = 1'b0;
        check_state("done", 1'b1, 1'b0, 7'd0);

        // Scaling: 0x8001 >>> 1 = 0xC000, 0x0003 >>> 1 = 0x0001
        beat(32'h8001_0003, 1'b1);
        check_state("scale", 1'b1, 1'b0, 7'd1);
        rd(6'd0, 32'hC000_0001, "scale_mem0");

        for (int k = 1; k < 10; k++) begin
            beat({16'(16'h0100 + k), 16'h00FF}, 1'b0);
        end
        check_state("pre_flush", 1'b1, 1'b0, 7'd10);

        // Flush with a beat offered: beat would land at bitrev(10) = 20
        In_Valid = 1'b1; In_Data = 32'h1234_5678; Flush = 1'b1;
        step();
        In_Valid = 1'b0; Flush = 1'b0;
        check_state("flush", 1'b1, 1'b0, 7'd0);
        rd(6'd20, 32'h000A_0000, "flush_no_write");

        // Frame 2, including a read-before-write of address 0 on beat 0
        for (int k = 0; k < 64; k++) begin
            if (k == 0) Rd_Addr = 6'd0;
            beat({16'(16'h1000 + k), 16'(k)}, 1'b0);
            if (k == 0)  expect_now("rbw_old", 0, 32'hC000_0001);
            if (k == 62) check_state("f2_beat62", 1'b1, 1'b0, 7'd63);
        end
        check_state("f2_full", 1'b0, 1'b1, 7'd64);
        rd(6'd0,  32'h1000_0000, "f2_addr0");
        rd(6'd1,  32'h1020_0020, "f2_addr1");
        rd(6'd24, 32'h1006_0006, "f2_addr24");

        // Start and Done together in FULL: only Start acts
        Start = 1'b1; Done = 1'b1; step(); Start = 1'b0; Done = 1'b0;
        check_state("start_done", 1'b0, 1'b0, 7'd64);
        Done = 1'b1; step(); Done = 1'b0;
        check_state("done_alone", 1'b1, 1'b0, 7'd0);

        // Asynchronous reset mid-frame
        for (int k = 0; k < 40; k++) begin
            beat({16'(16'h2000 + k), 16'h0000}, 1'b0);
        end
        check_state("mid40", 1'b1, 1'b0, 7'd40);
        rd(6'd0, 32'h2000_0000, "pre_reset_rd");
        @(negedge CLK);
        #1;
        nRST = 1'b0;
        #1;
        compare("arst.count", {25'd0, Sample_Count}, 32'd0);
        compare("arst.frame_ready", {31'd0, Frame_Ready}, 32'd0);
        compare("arst.in_ready", {31'd0, In_Ready}, 32'd1);
        compare("arst.rd_data", Rd_Data, 32'h0);
        step();
        nRST = 1'b1;
        rd(6'd0, 32'h2000_0000, "mem_kept");
        check_state("post_reset", 1'b1, 1'b0, 7'd0);

        step();
        step();
        if (q.size() != 0) compare("queue_drain", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_input_loader.md
Name: fft_input_loader

Overview:
- Entry point of the 64-point FFT datapath; the load side matching the output scaling stage at the back end.
- Accepts one packed complex sample per handshake, {real[31:16], imag[15:0]}, two's complement.
- Optionally pre-scales each sample and writes it into a 64-entry frame buffer at the bit-reversed address.
- Hands a complete frame to the FFT core with a start/done handshake; the core reads the buffer through a registered read port.

Parameters:
- N, 64, points per frame (fixed; LOG2N = 6).
- DW, 16, width of each real/imag component.
- IN_SHIFT, 1, arithmetic right-shift applied to each component when Scale = 1.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- nRST  in  1  asynchronous reset, active-low.
- In_Data  in  32  sample {real, imag}.
- In_Valid  in  1  In_Data valid.
- In_Ready  out  1  loader accepts a sample this cycle.
- Scale  in  1  1 = shift each component right by IN_SHIFT; sampled on each accepted beat.
- Flush  in  1  synchronous abort: discard the partial or complete frame.
- Frame_Ready  out  1  64 samples stored; waiting for Start.
- Start  in  1  FFT core takes the frame.
- Done  in  1  FFT core has finished with the buffer.
- Rd_Addr  in  6  core read address.
- Rd_Data  out  32  mem[Rd_Addr], registered.
- Sample_Count  out  7  samples stored in the current frame, 0..64.

Behaviour:
- State machine: LOAD, FULL, BUSY. Next state and the counter are registered.
- Reset (nRST = 0, asynchronous):
  - state = LOAD, cnt = 0, Rd_Data = 0.
  - Hence In_Ready = 1, Frame_Ready = 0, Sample_Count = 0.
  - Buffer contents are not cleared.
- Output decode:
  - In_Ready = (state == LOAD).
  - Frame_Ready = (state == FULL).
  - Sample_Count = cnt, with 64 shown in FULL and BUSY.
- LOAD:
  - A beat is accepted when In_Valid & In_Ready.
  - Write mem[bitrev(cnt[5:0])] <= scaled sample, then cnt += 1.
  - bitrev maps cnt[5:0] to {cnt[0], cnt[1], cnt[2], cnt[3], cnt[4], cnt[5]}.
  - On acceptance of the 64th beat (cnt == 63): go to FULL next cycle.
  - Start and Done are ignored in LOAD.
- FULL: In_Ready = 0, input stalls. Start = 1 -> BUSY next cycle.
- BUSY: Done = 1 -> LOAD next cycle with cnt = 0. Start is ignored.
- Flush = 1 in any state:
  - Next state LOAD, cnt = 0.
  - Any beat presented in the same cycle is not written and is lost. The source sees In_Ready = 1 in LOAD, so the beat counts as consumed but is discarded.
  - Flush has priority over Start, Done and the write.
- Scaling when Scale = 1: each component is shifted right arithmetically by IN_SHIFT, sign-filled, truncated toward minus infinity. No rounding, no saturation.
  - Example: real 0x8001 >> 1 = 0xC000; imag 0x0003 >> 1 = 0x0001.
- Scaling when Scale = 0: the sample is written unchanged.
- Read port:
  - Rd_Data <= mem[Rd_Addr] every cycle, in every state; latency 1 cycle.
  - A read of the address being written in the same cycle returns the old contents (read-before-write).
- Full/empty:
  - An empty frame (cnt = 0) is never reported.
  - FULL is entered exactly once per 64 accepted beats; no wrap to cnt = 0 without passing through FULL and BUSY, or a Flush.
- Simultaneous events: Start and Done asserted together in FULL -> BUSY only; Done is ignored because it was not in BUSY.

Decomposition:
- Shared package fft_pkg:
  - N_POINTS = 64, LOG2N = 6, DW = 16, SAMPLE_W = 32.
  - State encoding constants LOAD, FULL, BUSY.
  - bitrev6 function; the other FFT stages use the same function.
- One natural sub-module: frame_ram_64x32, a single-port write / single-port read RAM with registered read. It holds the buffer and the Rd_Data register.
- FSM, counter, scaler and bit-reverse stay in the top level.

Test Plan:
- Reset then stream samples k = 0..63 with Scale = 0, In_Data = {k, 16'h0}.
  - Frame_Ready rises the cycle after beat 63.
  - Reading address 32 -> Rd_Data = 0x0001_0000.
  - Reading address 1 -> Rd_Data = 0x0020_0000.
  - Reading address 63 -> 0x003F_0000.
- Scale = 1, IN_SHIFT = 1, single beat In_Data = 0x8001_0003 at k = 0 -> mem[0] = 0xC000_0001.
- Handshake hold in FULL:
  - In_Valid held high in FULL -> In_Ready = 0, no write.
  - Start -> BUSY; Done -> LOAD.
  - Sample_Count goes 64 -> 0, In_Ready = 1.
- Flush after 10 beats -> Sample_Count = 0, In_Ready = 1. A further 64 beats are then needed before Frame_Ready.
- Assert nRST = 0 asynchronously mid-frame (cnt = 40) -> Sample_Count = 0, Frame_Ready = 0 and Rd_Data = 0 immediately, without waiting for a clock edge.
- Start and Done together in FULL -> BUSY. Done alone then -> LOAD.
